// File: rtl/cp0_pkg.sv
//------------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the CP0 (CSR) execution pipe: implemented CSR
// addresses, the opcode field layout used by the CP0 issue queue, and the
// exception cause reported to the RTU.
//------------------------------------------------------------------------------
package cp0_pkg;

   // Machine-mode CSRs implemented by the local CSR file
   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   // Opcode layout: [1:0] selects the CSR function, [2] marks the immediate form
   localparam int OP_FN_LSB  = 0;
   localparam int OP_FN_MSB  = 1;
   localparam int OP_IMM_BIT = 2;

   typedef enum logic [1:0] {
      CSR_FN_ILL = 2'b00,
      CSR_FN_RW  = 2'b01,
      CSR_FN_RS  = 2'b10,
      CSR_FN_RC  = 2'b11
   } csrFnE;

   localparam logic [6:0] OPC_CSRRW  = 7'h01;
   localparam logic [6:0] OPC_CSRRS  = 7'h02;
   localparam logic [6:0] OPC_CSRRC  = 7'h03;
   localparam logic [6:0] OPC_CSRRWI = 7'h05;
   localparam logic [6:0] OPC_CSRRSI = 7'h06;
   localparam logic [6:0] OPC_CSRRCI = 7'h07;

   // Illegal-instruction cause code
   localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;

endpackage

// File: rtl/exu_cp0_if.sv
//------------------------------------------------------------------------------
// exu_cp0_if
// Bundles the CP0 pipe's issue, regfile-read, completion and CSR-export
// signals.
//   slave  : the CP0 execution pipe (consumes issue + rf data, drives
//            completion, regfile index and exported CSRs)
//   master : the surrounding core (issue queue, regfile, RTU)
//------------------------------------------------------------------------------
interface exu_cp0_if #(
   parameter int XLEN = 64
);
   logic            rtu_global_flush;
   logic            cp0_vld;
   logic [4:0]      cp0_iid;
   logic [6:0]      cp0_opcode;
   logic            cp0_psrc1_vld;
   logic [5:0]      cp0_psrc1;
   logic            cp0_imm_vld;
   logic [63:0]     cp0_imm;
   logic [5:0]      exu_rf_cp0_preg;
   logic [XLEN-1:0] rf_exu_cp0_data;
   logic            exu_rtu_cp0_cmplt_vld;
   logic [4:0]      exu_rtu_cp0_iid;
   logic [XLEN-1:0] exu_rtu_cp0_result;
   logic            exu_rtu_cp0_expt_vld;
   logic [4:0]      exu_rtu_cp0_expt_cause;
   logic [XLEN-1:0] cp0_csr_mtvec;
   logic [XLEN-1:0] cp0_csr_mepc;

   modport slave (
      input  rtu_global_flush, cp0_vld, cp0_iid, cp0_opcode, cp0_psrc1_vld,
             cp0_psrc1, cp0_imm_vld, cp0_imm, rf_exu_cp0_data,
      output exu_rf_cp0_preg, exu_rtu_cp0_cmplt_vld, exu_rtu_cp0_iid,
             exu_rtu_cp0_result, exu_rtu_cp0_expt_vld, exu_rtu_cp0_expt_cause,
             cp0_csr_mtvec, cp0_csr_mepc
   );

   modport master (
      output rtu_global_flush, cp0_vld, cp0_iid, cp0_opcode, cp0_psrc1_vld,
             cp0_psrc1, cp0_imm_vld, cp0_imm, rf_exu_cp0_data,
      input  exu_rf_cp0_preg, exu_rtu_cp0_cmplt_vld, exu_rtu_cp0_iid,
             exu_rtu_cp0_result, exu_rtu_cp0_expt_vld, exu_rtu_cp0_expt_cause,
             cp0_csr_mtvec, cp0_csr_mepc
   );
endinterface

// File: rtl/exu_cp0_csr_file.sv
//------------------------------------------------------------------------------
// exu_cp0_csr_file
// Local machine CSR storage, free-running mcycle, read mux, legality decode
// and the read-modify-write port used by the RF stage.
// Ports:
//   clk, rst_clk       clock, asynchronous active-low reset
//   opVld_i            op in RF is valid and not flushed this cycle
//   addr_i             CSR address of the op in RF
//   fn_i               CSR function (RW/RS/RC/illegal)
//   operand_i          resolved source operand
//   srcNonZero_i       operand comes from a register or a nonzero zimm
//   oldValue_o         CSR value before the op (0 when illegal)
//   illegal_o          op raises an illegal-instruction exception
//   mtvec_o, mepc_o    current mtvec / mepc
//------------------------------------------------------------------------------
module exu_cp0_csr_file
   import cp0_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int HARTID = 0
) (
   input  logic            clk,
   input  logic            rst_clk,
   input  logic            opVld_i,
   input  logic [11:0]     addr_i,
   input  csrFnE           fn_i,
   input  logic [XLEN-1:0] operand_i,
   input  logic            srcNonZero_i,
   output logic [XLEN-1:0] oldValue_o,
   output logic            illegal_o,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mepc_o
);

   logic [XLEN-1:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
   logic [XLEN-1:0] mcycle_q, mcycle_d;
   logic [XLEN-1:0] readVal, newVal;
   logic            implemented, writeReq, wrEn;

   // Read mux over the implemented CSRs; anything else is flagged as
   // unimplemented so the op can be turned into an exception.
   always_comb begin
      readVal     = '0;
      implemented = 1'b1;
      case (addr_i)
         CSR_MSTATUS:  readVal = mstatus_q;
         CSR_MTVEC:    readVal = mtvec_q;
         CSR_MSCRATCH: readVal = mscratch_q;
         CSR_MEPC:     readVal = mepc_q;
         CSR_MCAUSE:   readVal = mcause_q;
         CSR_MCYCLE:   readVal = mcycle_q;
         CSR_MHARTID:  readVal = XLEN'(HARTID);
         default:      implemented = 1'b0;
      endcase
   end

   // Decide whether the op wants to write, whether it is legal, and what the
   // new value would be. Set/clear with x0 or a zero zimm are pure reads,
   // which is what lets software read mhartid without trapping.
   always_comb begin
      writeReq = 1'b0;
      newVal   = readVal;
      case (fn_i)
         CSR_FN_RW: begin
            writeReq = 1'b1;
            newVal   = operand_i;
         end
         CSR_FN_RS: begin
            writeReq = srcNonZero_i;
            newVal   = readVal | operand_i;
         end
         CSR_FN_RC: begin
            writeReq = srcNonZero_i;
            newVal   = readVal & ~operand_i;
         end
         default: begin
            writeReq = 1'b0;
            newVal   = readVal;
         end
      endcase
      illegal_o  = ~implemented | (fn_i == CSR_FN_ILL) |
                   (writeReq & (addr_i == CSR_MHARTID));
      wrEn       = opVld_i & writeReq & ~illegal_o;
      oldValue_o = illegal_o ? '0 : readVal;
   end

   // mcycle counts every cycle, including flush cycles; a CSR write in the
   // same cycle wins over the increment.
   always_comb begin
      mcycle_d = mcycle_q + 1'b1;
      if (wrEn && (addr_i == CSR_MCYCLE)) begin
         mcycle_d = newVal;
      end
   end

   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         mcycle_q <= '0;
      end else begin
         mcycle_q <= mcycle_d;
      end
   end

   // Writable CSRs update at the RF->WB edge, so the next op in RF already
   // sees the new value without any forwarding.
   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         mstatus_q  <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else if (wrEn) begin
         case (addr_i)
            CSR_MSTATUS:  mstatus_q  <= newVal;
            CSR_MTVEC:    mtvec_q    <= newVal;
            CSR_MSCRATCH: mscratch_q <= newVal;
            CSR_MEPC:     mepc_q     <= newVal;
            CSR_MCAUSE:   mcause_q   <= newVal;
            default:      ;
         endcase
      end
   end

   assign mtvec_o = mtvec_q;
   assign mepc_o  = mepc_q;

endmodule

// File: rtl/exu_cp0.sv
//------------------------------------------------------------------------------
// exu_cp0
// CP0 (CSR) execution pipe: RF stage (regfile read, operand select, CSR
// access) followed by a WB stage that reports completion to the RTU.
// Ports:
//   clk, rst_clk   clock, asynchronous active-low reset
//   cp0If          exu_cp0_if.slave: issue from the CP0 queue, flush,
//                  regfile read index/data, RTU completion, mtvec/mepc export
//------------------------------------------------------------------------------
module exu_cp0
   import cp0_pkg::*;
#(
   parameter int HARTID = 0,
   parameter int XLEN   = 64
) (
   input  logic     clk,
   input  logic     rst_clk,
   exu_cp0_if.slave cp0If
);

   logic            rfVld_q;
   logic [4:0]      rfIid_q;
   logic [2:0]      rfOpcode_q;
   logic            rfPsrc1Vld_q;
   logic [5:0]      rfPsrc1_q;
   logic [11:0]     rfCsrAddr_q;
   logic [4:0]      rfZimm_q;

   logic            cmpltVld_q;
   logic [4:0]      wbIid_q;
   logic [XLEN-1:0] wbResult_q;
   logic            wbExpt_q;

   logic            opVld;
   logic            srcNonZero;
   logic [XLEN-1:0] operand;
   logic [XLEN-1:0] oldValue;
   logic            illegal;

   // RF stage capture. The payload only loads on a valid issue; the valid
   // itself is killed by a global flush in the issue cycle.
   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         rfVld_q      <= 1'b0;
         rfIid_q      <= '0;
         rfOpcode_q   <= '0;
         rfPsrc1Vld_q <= 1'b0;
         rfPsrc1_q    <= '0;
         rfCsrAddr_q  <= '0;
         rfZimm_q     <= '0;
      end else begin
         rfVld_q <= cp0If.cp0_vld & ~cp0If.rtu_global_flush;
         if (cp0If.cp0_vld) begin
            rfIid_q      <= cp0If.cp0_iid;
            rfOpcode_q   <= cp0If.cp0_opcode[2:0];
            rfPsrc1Vld_q <= cp0If.cp0_psrc1_vld;
            rfPsrc1_q    <= cp0If.cp0_psrc1;
            rfCsrAddr_q  <= cp0If.cp0_imm[11:0];
            rfZimm_q     <= cp0If.cp0_imm[16:12];
         end
      end
   end

   assign cp0If.exu_rf_cp0_preg = rfPsrc1_q;

   // Operand select: register data, else zimm for the immediate forms, else
   // x0. srcNonZero tells the CSR file whether set/clear may write at all.
   always_comb begin
      operand = '0;
      if (rfPsrc1Vld_q) begin
         operand = cp0If.rf_exu_cp0_data;
      end else if (rfOpcode_q[OP_IMM_BIT]) begin
         operand = {{(XLEN-5){1'b0}}, rfZimm_q};
      end
      srcNonZero = rfPsrc1Vld_q | (rfOpcode_q[OP_IMM_BIT] & (|rfZimm_q));
      opVld      = rfVld_q & ~cp0If.rtu_global_flush;
   end

   exu_cp0_csr_file #(
      .XLEN   (XLEN),
      .HARTID (HARTID)
   ) uCsrFile (
      .clk          (clk),
      .rst_clk      (rst_clk),
      .opVld_i      (opVld),
      .addr_i       (rfCsrAddr_q),
      .fn_i         (csrFnE'(rfOpcode_q[OP_FN_MSB:OP_FN_LSB])),
      .operand_i    (operand),
      .srcNonZero_i (srcNonZero),
      .oldValue_o   (oldValue),
      .illegal_o    (illegal),
      .mtvec_o      (cp0If.cp0_csr_mtvec),
      .mepc_o       (cp0If.cp0_csr_mepc)
   );

   // WB stage. A flush while the op sits in RF drops it here; a completion
   // already in WB during a flush is left alone for that cycle.
   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         cmpltVld_q <= 1'b0;
         wbIid_q    <= '0;
         wbResult_q <= '0;
         wbExpt_q   <= 1'b0;
      end else begin
         cmpltVld_q <= opVld;
         if (opVld) begin
            wbIid_q    <= rfIid_q;
            wbResult_q <= oldValue;
            wbExpt_q   <= illegal;
         end
      end
   end

   // Completion payload is forced to zero whenever no completion is shown.
   always_comb begin
      cp0If.exu_rtu_cp0_cmplt_vld  = cmpltVld_q;
      cp0If.exu_rtu_cp0_iid        = cmpltVld_q ? wbIid_q : 5'd0;
      cp0If.exu_rtu_cp0_result     = cmpltVld_q ? wbResult_q : '0;
      cp0If.exu_rtu_cp0_expt_vld   = cmpltVld_q & wbExpt_q;
      cp0If.exu_rtu_cp0_expt_cause = (cmpltVld_q & wbExpt_q) ? CAUSE_ILLEGAL : 5'd0;
   end

endmodule

// File: tb/tb_exu_cp0.sv
//------------------------------------------------------------------------------
// tb_exu_cp0
// Self-checking bench for exu_cp0: a table of CSR ops with expected results
// streamed back to back, plus hand-written flush, mcycle and reset sequences.
// Expected completions go into a scoreboard queue at issue time and are
// popped by a monitor on the falling edge.
//------------------------------------------------------------------------------
module tb_exu_cp0;
   import cp0_pkg::*;

   localparam int XLEN    = 64;
   localparam int HARTID3 = 3;

   typedef struct {
      logic [6:0]  opcode;
      logic        psrcVld;
      logic [5:0]  preg;
      logic [11:0] addr;
      logic [4:0]  zimm;
      logic [63:0] expResult;
      logic        expExpt;
   } vecT;

   typedef struct {
      logic [4:0]  iid;
      logic [63:0] result;
      logic        expt;
      logic        chkResult;
      int          due;
   } expT;

   logic clk = 1'b0;
   logic rst_clk = 1'b0;

   exu_cp0_if #(.XLEN(XLEN)) cp0If ();

   exu_cp0 #(
      .HARTID (HARTID3),
      .XLEN   (XLEN)
   ) dut (
      .clk     (clk),
      .rst_clk (rst_clk),
      .cp0If   (cp0If)
   );

   always #5 clk = ~clk;

   // Regfile model answering the combinational read port
   logic [63:0] regFile [64];
   assign cp0If.rf_exu_cp0_data = regFile[cp0If.exu_rf_cp0_preg];

   int          cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   expT         sbQ [$];
   logic [63:0] capResult [32];
   logic [4:0]  nextIid = '0;
   logic [4:0]  lastIid;
   vecT         vecs [21];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reportFail(input string name, input int act, input int exp);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (rst_clk) begin
         while (sbQ.size() > 0 && sbQ[0].due < cyc) begin
            reportFail("missing completion", cyc, sbQ[0].due);
            void'(sbQ.pop_front());
         end
         if (cp0If.exu_rtu_cp0_cmplt_vld) begin
            if (sbQ.size() == 0) begin
               reportFail("unexpected completion", 1, 0);
            end else begin
               expT e;
               e = sbQ.pop_front();
               checkOutput("cmplt cycle", 64'(cyc), 64'(e.due));
               checkOutput("cmplt iid", 64'(cp0If.exu_rtu_cp0_iid), 64'(e.iid));
               if (e.chkResult) begin
                  checkOutput("cmplt result", cp0If.exu_rtu_cp0_result, e.result);
               end
               checkOutput("cmplt expt", 64'(cp0If.exu_rtu_cp0_expt_vld), 64'(e.expt));
               checkOutput("cmplt cause", 64'(cp0If.exu_rtu_cp0_expt_cause),
                           e.expt ? 64'(CAUSE_ILLEGAL) : 64'd0);
               capResult[e.iid] = cp0If.exu_rtu_cp0_result;
            end
         end else begin
            checkOutput("idle result", cp0If.exu_rtu_cp0_result, 64'd0);
            checkOutput("idle iid/expt", {52'd0, cp0If.exu_rtu_cp0_iid,
                        cp0If.exu_rtu_cp0_expt_vld, cp0If.exu_rtu_cp0_expt_cause,
                        1'b0}, 64'd0);
         end
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive one op for one cycle; optionally push its expected completion
   task automatic applyStimulus(input logic [6:0] op, input logic psrcVld, input logic [5:0] preg,
                                input logic [11:0] addr, input logic [4:0] zimm,
                                input logic [63:0] expRes, input logic expExpt,
                                input logic chk, input logic track);
      expT e;
      cp0If.cp0_vld       = 1'b1;
      cp0If.cp0_iid       = nextIid;
      cp0If.cp0_opcode    = op;
      cp0If.cp0_psrc1_vld = psrcVld;
      cp0If.cp0_psrc1     = preg;
      cp0If.cp0_imm_vld   = 1'b1;
      cp0If.cp0_imm       = {47'd0, zimm, addr};
      if (track) begin
         e.iid       = nextIid;
         e.result    = expRes;
         e.expt      = expExpt;
         e.chkResult = chk;
         e.due       = cyc + 2;
         sbQ.push_back(e);
      end
      lastIid = nextIid;
      nextIid = nextIid + 5'd1;
      stepCycle();
      cp0If.cp0_vld = 1'b0;
   endtask

   initial begin
      int          w;
      int          r;
      int          relCyc;
      logic [4:0]  iidA;
      logic [4:0]  iidB;
      logic [11:0] zeroAddrs [5];

      for (int i = 0; i < 64; i++) regFile[i] = 64'd0;
      regFile[5]  = 64'hDEAD_BEEF;
      regFile[7]  = 64'hFF00;
      regFile[9]  = 64'h0F0F;
      regFile[11] = 64'hFFFF_FFFF_FFFF_FFFF;

      cp0If.rtu_global_flush = 1'b0;
      cp0If.cp0_vld          = 1'b0;
      cp0If.cp0_iid          = '0;
      cp0If.cp0_opcode       = '0;
      cp0If.cp0_psrc1_vld    = 1'b0;
      cp0If.cp0_psrc1        = '0;
      cp0If.cp0_imm_vld      = 1'b0;
      cp0If.cp0_imm          = '0;

      vecs[0]  = '{OPC_CSRRW,  1'b1, 6'd5, CSR_MSCRATCH, 5'd0,  64'h0,         1'b0};
      vecs[1]  = '{OPC_CSRRS,  1'b0, 6'd5, CSR_MSCRATCH, 5'd0,  64'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{OPC_CSRRSI, 1'b0, 6'd5, CSR_MTVEC,    5'd4,  64'h0,         1'b0};
      vecs[3]  = '{OPC_CSRRCI, 1'b0, 6'd5, CSR_MTVEC,    5'd4,  64'h4,         1'b0};
      vecs[4]  = '{OPC_CSRRS,  1'b0, 6'd5, CSR_MTVEC,    5'd0,  64'h0,         1'b0};
      vecs[5]  = '{OPC_CSRRW,  1'b1, 6'd5, CSR_MHARTID,  5'd0,  64'h0,         1'b1};
      vecs[6]  = '{OPC_CSRRS,  1'b0, 6'd5, CSR_MHARTID,  5'd0,  64'h3,         1'b0};
      vecs[7]  = '{OPC_CSRRW,  1'b1, 6'd5, 12'h7C0,      5'd0,  64'h0,         1'b1};
      vecs[8]  = '{7'h00,      1'b1, 6'd7, CSR_MSCRATCH, 5'd0,  64'h0,         1'b1};
      vecs[9]  = '{OPC_CSRRS,  1'b1, 6'd7, CSR_MHARTID,  5'd0,  64'h0,         1'b1};
      vecs[10] = '{OPC_CSRRSI, 1'b0, 6'd5, CSR_MHARTID,  5'd0,  64'h3,         1'b0};
      vecs[11] = '{OPC_CSRRW,  1'b1, 6'd7, CSR_MEPC,     5'd0,  64'h0,         1'b0};
      vecs[12] = '{OPC_CSRRS,  1'b1, 6'd9, CSR_MEPC,     5'd0,  64'hFF00,      1'b0};
      vecs[13] = '{OPC_CSRRC,  1'b1, 6'd7, CSR_MEPC,     5'd0,  64'hFF0F,      1'b0};
      vecs[14] = '{OPC_CSRRWI, 1'b0, 6'd5, CSR_MCAUSE,   5'h1F, 64'h0,         1'b0};
      vecs[15] = '{OPC_CSRRCI, 1'b0, 6'd5, CSR_MCAUSE,   5'd0,  64'h1F,        1'b0};
      vecs[16] = '{OPC_CSRRS,  1'b0, 6'd5, CSR_MCAUSE,   5'd0,  64'h1F,        1'b0};
      vecs[17] = '{OPC_CSRRW,  1'b1, 6'd9, CSR_MSTATUS,  5'd0,  64'h0,         1'b0};
      vecs[18] = '{OPC_CSRRC,  1'b0, 6'd5, CSR_MSTATUS,  5'd0,  64'h0F0F,      1'b0};
      vecs[19] = '{OPC_CSRRS,  1'b0, 6'd5, CSR_MSTATUS,  5'd0,  64'h0F0F,      1'b0};
      vecs[20] = '{OPC_CSRRS,  1'b0, 6'd5, CSR_MSCRATCH, 5'd0,  64'hDEAD_BEEF, 1'b0};

      // Reset state
      stepCycle();
      stepCycle();
      checkOutput("reset cmplt_vld", 64'(cp0If.exu_rtu_cp0_cmplt_vld), 64'd0);
      checkOutput("reset result", cp0If.exu_rtu_cp0_result, 64'd0);
      checkOutput("reset preg", 64'(cp0If.exu_rf_cp0_preg), 64'd0);
      checkOutput("reset mtvec", cp0If.cp0_csr_mtvec, 64'd0);
      checkOutput("reset mepc", cp0If.cp0_csr_mepc, 64'd0);
      rst_clk = 1'b1;
      stepCycle();

      // Table of ops issued back to back
      $display("[TB] table-driven CSR ops");
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].opcode, vecs[i].psrcVld, vecs[i].preg, vecs[i].addr,
                       vecs[i].zimm, vecs[i].expResult, vecs[i].expExpt, 1'b1, 1'b1);
      end
      repeat (4) stepCycle();
      checkOutput("mtvec after set/clear", cp0If.cp0_csr_mtvec, 64'd0);
      checkOutput("mepc after rmw", cp0If.cp0_csr_mepc, 64'hF);

      // Flush while the op is in RF: no completion, no write
      $display("[TB] flush in RF");
      applyStimulus(OPC_CSRRW, 1'b1, 6'd5, CSR_MEPC, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      cp0If.rtu_global_flush = 1'b1;
      stepCycle();
      cp0If.rtu_global_flush = 1'b0;
      repeat (3) stepCycle();
      checkOutput("mepc after RF flush", cp0If.cp0_csr_mepc, 64'hF);

      // Flush in the WB cycle: A completes that cycle, B (in RF) is dropped
      $display("[TB] flush in WB");
      applyStimulus(OPC_CSRRS, 1'b0, 6'd5, CSR_MEPC, 5'd0, 64'hF, 1'b0, 1'b1, 1'b1);
      applyStimulus(OPC_CSRRW, 1'b1, 6'd5, CSR_MEPC, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      cp0If.rtu_global_flush = 1'b1;
      @(negedge clk);
      checkOutput("cmplt during WB flush", 64'(cp0If.exu_rtu_cp0_cmplt_vld), 64'd1);
      stepCycle();
      cp0If.rtu_global_flush = 1'b0;
      @(negedge clk);
      checkOutput("cmplt after WB flush", 64'(cp0If.exu_rtu_cp0_cmplt_vld), 64'd0);
      repeat (3) stepCycle();
      checkOutput("mepc after WB flush", cp0If.cp0_csr_mepc, 64'hF);

      // mcycle read twice, ten cycles apart
      $display("[TB] mcycle delta");
      applyStimulus(OPC_CSRRS, 1'b0, 6'd5, CSR_MCYCLE, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      iidA = lastIid;
      repeat (9) stepCycle();
      applyStimulus(OPC_CSRRS, 1'b0, 6'd5, CSR_MCYCLE, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      iidB = lastIid;
      repeat (4) stepCycle();
      checkOutput("mcycle delta", capResult[iidB] - capResult[iidA], 64'd10);

      // mcycle write of all-ones, then wrap: the value lands at w+2, wraps
      // to 0 at w+3, and a read issued at r samples it after edge r+1
      $display("[TB] mcycle wrap");
      w = cyc;
      applyStimulus(OPC_CSRRW, 1'b1, 6'd11, CSR_MCYCLE, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      repeat (4) stepCycle();
      r = cyc;
      applyStimulus(OPC_CSRRS, 1'b0, 6'd5, CSR_MCYCLE, 5'd0, 64'(r - w - 2), 1'b0, 1'b1, 1'b1);
      repeat (4) stepCycle();

      // Async reset between issue and completion
      $display("[TB] async reset mid-op");
      applyStimulus(OPC_CSRRW, 1'b1, 6'd7, CSR_MSCRATCH, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      #1;
      rst_clk = 1'b0;
      #1;
      checkOutput("cmplt in reset", 64'(cp0If.exu_rtu_cp0_cmplt_vld), 64'd0);
      checkOutput("mtvec in reset", cp0If.cp0_csr_mtvec, 64'd0);
      checkOutput("mepc in reset", cp0If.cp0_csr_mepc, 64'd0);
      #1;
      rst_clk = 1'b1;
      relCyc = cyc;
      repeat (3) stepCycle();
      zeroAddrs[0] = CSR_MSTATUS;
      zeroAddrs[1] = CSR_MTVEC;
      zeroAddrs[2] = CSR_MSCRATCH;
      zeroAddrs[3] = CSR_MEPC;
      zeroAddrs[4] = CSR_MCAUSE;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(OPC_CSRRS, 1'b0, 6'd5, zeroAddrs[i], 5'd0, 64'd0, 1'b0, 1'b1, 1'b1);
      end
      r = cyc;
      applyStimulus(OPC_CSRRS, 1'b0, 6'd5, CSR_MCYCLE, 5'd0, 64'(r + 1 - relCyc), 1'b0, 1'b1, 1'b1);
      applyStimulus(OPC_CSRRS, 1'b0, 6'd5, CSR_MHARTID, 5'd0, 64'd3, 1'b0, 1'b1, 1'b1);
      repeat (5) stepCycle();

      checkOutput("scoreboard drained", 64'(sbQ.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
